// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives a combinational program ROM and buffers {pc, instr}
// pairs in a small FIFO for decode. Optional macro INSTR_FETCH_MISALIGN_TRAP_EN adds a FAULT state for misaligned redirects.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  typedef enum logic {RUN, FAULT} state_t;

  state_t             state, state_nxt;
  logic [31:0]        fetch_pc;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   head, tail;
  logic [31:0]        pc_mem    [DEPTH];
  logic [31:0]        instr_mem [DEPTH];
  logic               fetch_en;
  logic               transfer;
  logic               push;
  logic [31:0]        redirect_target;

  assign rom_addr = fetch_pc;
  assign if_valid = (count != '0);
  assign if_pc    = pc_mem[head];
  assign if_instr = instr_mem[head];
  assign transfer = if_valid & if_ready;
  // A full buffer can still accept a word when the head leaves on the same edge.
  assign push     = fetch_en & ~redirect_valid & ((count != FULL) | transfer);

`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned      = (redirect_pc[1:0] != 2'b00);
  assign redirect_target = redirect_pc;
`else
  // Low address bits are forced to word alignment.
  assign redirect_target = {redirect_pc[31:2], redirect_pc[1:0] & 2'b00};
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    if (redirect_valid) state_nxt = misaligned ? FAULT : RUN;
`endif
  end

  always_comb begin
    fetch_en = (state == RUN);
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    fetch_fault = (state == FAULT);
`else
    fetch_fault = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect_valid) begin
      // Flush; any concurrent transfer has already been seen by decode this edge.
      fetch_pc <= redirect_target;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        tail     <= (tail == LAST) ? '0 : tail + 1'b1;
      end
      if (transfer) head <= (head == LAST) ? '0 : head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(transfer);
    end
  end

  // NOTE: buffer storage has no reset; count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= rom_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: reset, streaming, backpressure,
// redirect, PC wrap (second instance), misaligned redirect and async reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr, rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        fetch_fault;

  logic [31:0] rom_addr2, rom_data2;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;
  logic        if_valid2;
  logic [31:0] if_instr2, if_pc2;
  logic        fetch_fault2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Program ROM: a LUI at address 0, distinct tagged words elsewhere.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h1234_52B7;
    return a ^ 32'hA5A5_0013;
  endfunction

  always_comb rom_data  = rom_word(rom_addr);
  always_comb rom_data2 = rom_word(rom_addr2);

  instr_fetch dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .fetch_fault(fetch_fault)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .if_valid(if_valid2), .if_ready(if_ready), .if_instr(if_instr2),
    .if_pc(if_pc2), .fetch_fault(fetch_fault2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst            = 1'b1;
    if_ready       = ready;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_rom_addr", rom_addr, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_rom_addr_wrap", rom_addr2, 32'hFFFF_FFF8);

    // Streaming with decode always ready; wrap instance runs alongside.
    rst = 1'b0; if_ready = 1'b1;
    check("pre_first_edge_valid", 32'(if_valid), 32'd0);
    step();
    check("lui_opcode", 32'(if_instr[6:0]), 32'h37);
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", 32'(if_valid), 32'd1);
      check("stream_pc", if_pc, 32'(4 * i));
      check("stream_instr", if_instr, rom_word(32'(4 * i)));
      check("wrap_pc", if_pc2, 32'hFFFF_FFF8 + 32'(4 * i));
      step();
    end

    // Backpressure: buffer fills to two entries and fetch stalls at 8.
    do_reset(1'b0);
    repeat (4) step();
    check("stall_rom_addr", rom_addr, 32'h8);
    check("stall_valid", 32'(if_valid), 32'd1);
    check("stall_head_pc", if_pc, 32'h0);
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_pc", if_pc, 32'(4 * i));
      check("drain_instr", if_instr, rom_word(32'(4 * i)));
      step();
    end

    // Redirect on the same edge as the transfer of pc 4.
    do_reset(1'b1);
    step();
    check("redir_pc0", if_pc, 32'h0);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    check("redir_accept_valid", 32'(if_valid), 32'd1);
    check("redir_accept_pc", if_pc, 32'h4);
    step();
    redirect_valid = 1'b0;
    check("redir_bubble_valid", 32'(if_valid), 32'd0);
    check("redir_rom_addr", rom_addr, 32'h10);
    step();
    check("redir_target_valid", 32'(if_valid), 32'd1);
    check("redir_target_pc", if_pc, 32'h10);
    check("redir_target_instr", if_instr, rom_word(32'h10));

    // Misaligned redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    step();
    redirect_valid = 1'b0;
`ifdef INSTR_FETCH_MISALIGN_TRAP_EN
    check("mis_fault", 32'(fetch_fault), 32'd1);
    check("mis_valid", 32'(if_valid), 32'd0);
    step(); step();
    check("mis_fault_held", 32'(fetch_fault), 32'd1);
    check("mis_valid_held", 32'(if_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    check("mis_recover_fault", 32'(fetch_fault), 32'd0);
    check("mis_recover_bubble", 32'(if_valid), 32'd0);
    step();
    check("mis_recover_valid", 32'(if_valid), 32'd1);
    check("mis_recover_pc", if_pc, 32'h20);
`else
    check("mis_fault", 32'(fetch_fault), 32'd0);
    check("mis_valid", 32'(if_valid), 32'd0);
    check("mis_rom_addr", rom_addr, 32'h4);
    step();
    check("mis_aligned_valid", 32'(if_valid), 32'd1);
    check("mis_aligned_pc", if_pc, 32'h4);
`endif

    // Asynchronous reset mid-cycle with a full buffer.
    do_reset(1'b0);
    step(); step();
    check("async_pre_valid", 32'(if_valid), 32'd1);
    check("async_pre_rom_addr", rom_addr, 32'h8);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(if_valid), 32'd0);
    check("async_rom_addr", rom_addr, 32'h0);
    check("async_rom_addr_wrap", rom_addr2, 32'hFFFF_FFF8);
    step();
    rst = 1'b0;
    step();
    check("post_async_valid", 32'(if_valid), 32'd1);
    check("post_async_pc", if_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
